// File: rtl/pc_unit.sv
// pc_unit -- program counter stage fed by the jump selector.
//
// Each retired instruction (step=1) does one of four things:
// return, call, jump or increment. A small LIFO holds return
// addresses. An overflow or underflow of that stack puts the block
// into a sticky FAULT state. Only reset leaves FAULT.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   step         advance enable, one PC update per high cycle
//   inc_n        jump selector: 1 = increment, 0 = load target
//   target       branch / call destination
//   call         push pc+1 and jump to target
//   ret          pop return address into pc (wins over call)
//   pc           registered program counter
//   stack_empty  return stack holds no entries
//   stack_full   return stack holds STACK_DEPTH entries
//   fault        sticky overflow/underflow indicator
module pc_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step,
  input  logic                inc_n,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                call,
  input  logic                ret,
  output logic [PC_WIDTH-1:0] pc,
  output logic                stack_empty,
  output logic                stack_full,
  output logic                fault
);

  // The depth counter needs one extra code so it can hold STACK_DEPTH itself.
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int DW = $clog2(STACK_DEPTH + 1);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t              state;
  logic [DW-1:0]       depth;
  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_plus1;
  logic [DW-1:0]       top_depth;
  logic [AW-1:0]       push_idx;
  logic [AW-1:0]       top_idx;
  logic                push;

  assign pc_plus1  = pc + PC_WIDTH'(1);
  assign top_depth = depth - DW'(1);

  // The entry at index depth is the next free slot. Index depth-1 is
  // the top of the stack. Each index is used only when it is valid
  // (not full for a push, not empty for a pop).
  assign push_idx = depth[AW-1:0];
  assign top_idx  = top_depth[AW-1:0];

  assign stack_empty = (depth == '0);
  assign stack_full  = (depth == DW'(STACK_DEPTH));

  // A push happens only for a legal call: RUN state, stepping,
  // not masked by ret, and room on the stack.
  assign push = (state == RUN) && step && call && !ret && !stack_full;

  // Control FSM with registered pc, depth and fault. In FAULT
  // everything freezes. The priority order is ret > call > jump > increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= PC_WIDTH'(RESET_PC);
      depth <= '0;
      fault <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (step) begin
            if (ret) begin
              if (stack_empty) begin
                state <= FAULT;
                fault <= 1'b1;
              end else begin
                pc    <= stack_mem[top_idx];
                depth <= top_depth;
              end
            end else if (call) begin
              if (stack_full) begin
                state <= FAULT;
                fault <= 1'b1;
              end else begin
                pc    <= target;
                depth <= depth + DW'(1);
              end
            end else if (!inc_n) begin
              pc <= target;
            end else begin
              pc <= pc_plus1;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
          fault <= 1'b1;
        end
        default: begin
          state <= FAULT;
          fault <= 1'b1;
        end
      endcase
    end
  end

  // Return-address storage has no reset. The depth counter alone
  // decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[push_idx] <= pc_plus1;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- self-checking bench for pc_unit.
//
// A behavioural model (a queue used as the return stack) tracks the
// expected pc and flags. A compare process checks the DUT against the
// model on every falling edge. Directed sequences with hand-computed
// literal expectations pin the model. A long randomized run then
// follows.
module tb_pc_unit;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b1;
  logic         step   = 1'b0;
  logic         inc_n  = 1'b1;
  logic [W-1:0] target = '0;
  logic         call   = 1'b0;
  logic         ret    = 1'b0;
  logic [W-1:0] pc;
  logic         stack_empty;
  logic         stack_full;
  logic         fault;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  // Behavioural model state
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stack [$];
  bit           m_fault;

  pc_unit #(.PC_WIDTH(W), .STACK_DEPTH(D), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .step        (step),
    .inc_n       (inc_n),
    .target      (target),
    .call        (call),
    .ret         (ret),
    .pc          (pc),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic resetModel();
    m_pc    = '0;
    m_stack.delete();
    m_fault = 1'b0;
  endtask

  // Model update at each rising edge. The rules are written directly
  // in terms of a LIFO queue.
  always @(posedge clk) begin
    if (rst_n && step && !m_fault) begin
      if (ret) begin
        if (m_stack.size() == 0) m_fault = 1'b1;
        else m_pc = m_stack.pop_back();
      end else if (call) begin
        if (m_stack.size() == D) m_fault = 1'b1;
        else begin
          m_stack.push_back(m_pc + 8'd1);
          m_pc = target;
        end
      end else if (!inc_n) begin
        m_pc = target;
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process, active once the first reset has been applied.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_pc",    32'(pc),          32'(m_pc));
      checkOutput("model_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
      checkOutput("model_full",  32'(stack_full),  32'(m_stack.size() == D));
      checkOutput("model_fault", 32'(fault),       32'(m_fault));
    end
  end

  // Drive one cycle of inputs. Returns 1 time unit after the edge that
  // consumed them, so the outputs already show the result.
  task automatic applyStimulus(input logic s, input logic i, input logic [W-1:0] t,
                               input logic c, input logic r);
    step   = s;
    inc_n  = i;
    target = t;
    call   = c;
    ret    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    step  = 1'b0;
    call  = 1'b0;
    ret   = 1'b0;
    rst_n = 1'b0;
    resetModel();
    #1;
    checkOutput("rst_pc",    32'(pc),          32'h00);
    checkOutput("rst_empty", 32'(stack_empty), 32'h1);
    checkOutput("rst_full",  32'(stack_full),  32'h0);
    checkOutput("rst_fault", 32'(fault),       32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #2;
    doReset();
    check_en = 1'b1;

    // Increment from reset
    applyStimulus(1, 1, 8'h00, 0, 0); checkOutput("inc1", 32'(pc), 32'h01);
    applyStimulus(1, 1, 8'h00, 0, 0); checkOutput("inc2", 32'(pc), 32'h02);
    applyStimulus(1, 1, 8'h00, 0, 0); checkOutput("inc3", 32'(pc), 32'h03);
    checkOutput("inc_empty", 32'(stack_empty), 32'h1);
    checkOutput("inc_fault", 32'(fault), 32'h0);

    // Wrap around
    applyStimulus(1, 0, 8'hFE, 0, 0); checkOutput("load_fe", 32'(pc), 32'hFE);
    applyStimulus(1, 1, 8'h00, 0, 0); checkOutput("wrap_ff", 32'(pc), 32'hFF);
    applyStimulus(1, 1, 8'h00, 0, 0); checkOutput("wrap_00", 32'(pc), 32'h00);

    // Jump and step=0 hold
    applyStimulus(1, 0, 8'h10, 0, 0); checkOutput("load_10", 32'(pc), 32'h10);
    applyStimulus(1, 0, 8'h40, 0, 0); checkOutput("jump_40", 32'(pc), 32'h40);
    applyStimulus(0, 0, 8'h80, 0, 0); checkOutput("hold_40", 32'(pc), 32'h40);
    applyStimulus(0, 1, 8'h80, 1, 0); checkOutput("hold_call", 32'(pc), 32'h40);

    // Nested calls
    applyStimulus(1, 0, 8'h05, 0, 0); checkOutput("load_05", 32'(pc), 32'h05);
    applyStimulus(1, 1, 8'h20, 1, 0); checkOutput("call_20", 32'(pc), 32'h20);
    applyStimulus(1, 1, 8'h30, 1, 0); checkOutput("call_30", 32'(pc), 32'h30);
    checkOutput("nest_empty", 32'(stack_empty), 32'h0);
    checkOutput("nest_full",  32'(stack_full),  32'h0);
    applyStimulus(1, 0, 8'hAA, 0, 1); checkOutput("ret_21", 32'(pc), 32'h21);
    applyStimulus(1, 0, 8'hAA, 0, 1); checkOutput("ret_06", 32'(pc), 32'h06);
    checkOutput("ret_empty", 32'(stack_empty), 32'h1);

    // Overflow
    doReset();
    applyStimulus(1, 1, 8'h11, 1, 0);
    applyStimulus(1, 1, 8'h22, 1, 0);
    applyStimulus(1, 1, 8'h33, 1, 0);
    applyStimulus(1, 1, 8'h44, 1, 0);
    checkOutput("ovf_full", 32'(stack_full), 32'h1);
    applyStimulus(1, 1, 8'h55, 1, 0);
    checkOutput("ovf_pc",    32'(pc),    32'h44);
    checkOutput("ovf_fault", 32'(fault), 32'h1);
    applyStimulus(1, 1, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h77, 0, 1);
    checkOutput("frozen_pc",   32'(pc),         32'h44);
    checkOutput("frozen_full", 32'(stack_full), 32'h1);
    doReset();

    // Underflow from reset
    applyStimulus(1, 1, 8'h00, 0, 1);
    checkOutput("unf_fault", 32'(fault), 32'h1);
    checkOutput("unf_pc",    32'(pc),    32'h00);
    doReset();

    // call+ret together with one entry whose value is 0x09
    applyStimulus(1, 0, 8'h08, 0, 0);
    applyStimulus(1, 1, 8'h50, 1, 0);
    applyStimulus(1, 0, 8'h60, 1, 1);
    checkOutput("cr_pc",    32'(pc),          32'h09);
    checkOutput("cr_empty", 32'(stack_empty), 32'h1);
    checkOutput("cr_fault", 32'(fault),       32'h0);

    // Push then immediate pop returns the just-pushed address
    applyStimulus(1, 1, 8'h70, 1, 0);
    applyStimulus(1, 1, 8'h00, 0, 1);
    checkOutput("pushpop_pc", 32'(pc), 32'h0A);

    // Reset asserted mid-cycle with a half-filled stack
    applyStimulus(1, 1, 8'h90, 1, 0);
    applyStimulus(1, 1, 8'hA0, 1, 0);
    #2;
    doReset();
    applyStimulus(1, 1, 8'h00, 0, 0); checkOutput("after_rst", 32'(pc), 32'h01);

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0 || (m_fault && $urandom_range(0, 7) == 0)) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0,
                      $urandom_range(0, 9) < 7,
                      W'($urandom),
                      $urandom_range(0, 4) == 0,
                      $urandom_range(0, 4) == 0);
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
